// File: rtl/paddle_axis_pkg.sv
// paddle_axis_pkg: shared FSM states, PS/2 packet field offsets and saturating add.
package paddle_axis_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ACC_X, ACC_Y} state_t;
  localparam int PKT_W = 25;
  localparam int BTN = 0, XS = 4, YS = 5, X = 8, Y = 16, STB = 24;
  function automatic int sat_add(input int acc, input int d, input int w);
    int s, hi;
    s = acc + d;
    hi = (1 << (w - 1)) - 1;
    return s > hi ? hi : s < -hi - 1 ? -hi - 1 : s;
  endfunction
endpackage

// File: rtl/axis_step.sv
// axis_step: one axis update - sign-extend, sensitivity shift, optional invert, clamp, saturating add.
module axis_step import paddle_axis_pkg::*; #(
  parameter int OUT_W = 8,
  parameter int STEP_MAX = 10
) (
  input  logic                    sign,
  input  logic [7:0]              mag,
  input  logic [1:0]              sens,
  input  logic                    inv,
  input  logic signed [OUT_W-1:0] acc,
  output logic signed [OUT_W-1:0] nxt
);
  logic signed [9:0] sh, d;
  int di, cl;
  assign sh = $signed({sign, sign, mag}) >>> sens;
  assign d = inv ? -sh : sh;
  always_comb begin
    di = int'(d);
    cl = di > STEP_MAX ? STEP_MAX : di < -STEP_MAX ? -STEP_MAX : di;
    nxt = OUT_W'(sat_add(int'(acc), cl, OUT_W));
  end
endmodule

// File: rtl/paddle_axis_emu.sv
// paddle_axis_emu: PS/2 mice to saturating paddle axes, time-shared datapath, analog joystick override.
module paddle_axis_emu import paddle_axis_pkg::*; #(
  parameter int NUM_MICE = 2,
  parameter int OUT_W = 8,
  parameter int STEP_MAX = 10
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic [PKT_W*NUM_MICE-1:0]   ps2_mouse,
  input  logic [16*NUM_MICE-1:0]      joya,
  input  logic [1:0]                  sens,
  input  logic                        invert_y,
  input  logic                        recenter,
  output logic [OUT_W*NUM_MICE-1:0]   ax,
  output logic [OUT_W*NUM_MICE-1:0]   ay,
  output logic [3*NUM_MICE-1:0]       btn,
  output logic [NUM_MICE-1:0]         emu,
  output logic [NUM_MICE-1:0]         upd,
  output logic [NUM_MICE-1:0]         ovr
);
  localparam int CW = NUM_MICE > 1 ? $clog2(NUM_MICE) : 1;
  state_t state, state_n;
  logic [CW-1:0] cur, cur_n;
  logic armed, is_y;
  logic [NUM_MICE-1:0] old_stb, pend, ev, jov, emu_n;
  logic [PKT_W-1:0] shadow [NUM_MICE];
  logic [PKT_W-1:0] work, pk;
  logic signed [OUT_W-1:0] acc_x [NUM_MICE], acc_y [NUM_MICE], acc_x_n [NUM_MICE], acc_y_n [NUM_MICE];
  logic signed [OUT_W-1:0] step_in, step_out;

  for (genvar g = 0; g < NUM_MICE; g++) begin : g_ch
    assign ev[g] = armed & (ps2_mouse[g*PKT_W+STB] ^ old_stb[g]);
    assign jov[g] = |joya[g*16+:16];
  end

  // X is taken straight from the shadow during LOAD so a packet landing just before LOAD still wins
  assign is_y = state == ACC_X;
  assign pk = is_y ? work : shadow[cur];
  assign step_in = is_y ? acc_y[cur] : acc_x[cur];

  axis_step #(.OUT_W(OUT_W), .STEP_MAX(STEP_MAX)) u_step (
    .sign(pk[is_y ? YS : XS]),
    .mag (is_y ? pk[Y+:8] : pk[X+:8]),
    .sens(sens),
    .inv (is_y & invert_y),
    .acc (step_in),
    .nxt (step_out)
  );

  always_comb begin
    state_n = state;
    cur_n = cur;
    emu_n = emu;
    acc_x_n = acc_x;
    acc_y_n = acc_y;
    case (state)
      IDLE: begin
        for (int i = NUM_MICE - 1; i >= 0; i--) if (pend[i]) cur_n = CW'(i);
        state_n = |pend ? LOAD : IDLE;
      end
      LOAD: begin
        acc_x_n[cur] = step_out;
        state_n = ACC_X;
      end
      ACC_X: begin
        acc_y_n[cur] = step_out;
        emu_n[cur] = 1'b1;
        state_n = ACC_Y;
      end
      default: state_n = IDLE;
    endcase
    for (int i = 0; i < NUM_MICE; i++) begin
      if (recenter || jov[i]) begin
        acc_x_n[i] = '0;
        acc_y_n[i] = '0;
      end
      if (jov[i]) emu_n[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cur <= '0;
      armed <= 1'b0;
      old_stb <= '0;
      pend <= '0;
      work <= '0;
      emu <= '0;
      upd <= '0;
      ovr <= '0;
      btn <= '0;
      ax <= '0;
      ay <= '0;
      for (int i = 0; i < NUM_MICE; i++) begin
        shadow[i] <= '0;
        acc_x[i] <= '0;
        acc_y[i] <= '0;
      end
    end else begin
      state <= state_n;
      cur <= cur_n;
      armed <= 1'b1;
      emu <= emu_n;
      if (state == LOAD) work <= shadow[cur];
      for (int i = 0; i < NUM_MICE; i++) begin
        old_stb[i] <= ps2_mouse[i*PKT_W+STB];
        if (ev[i]) shadow[i] <= ps2_mouse[i*PKT_W+:PKT_W];
        pend[i] <= ~jov[i] & (ev[i] | (pend[i] & ~(state == LOAD && cur == CW'(i))));
        ovr[i] <= ~recenter & (ovr[i] | (ev[i] & pend[i]));
        acc_x[i] <= acc_x_n[i];
        acc_y[i] <= acc_y_n[i];
        upd[i] <= state == ACC_X && cur == CW'(i) && !jov[i];
        if (jov[i]) btn[i*3+:3] <= '0;
        else if (state == ACC_X && cur == CW'(i)) btn[i*3+:3] <= work[BTN+:3];
        ax[i*OUT_W+:OUT_W] <= emu_n[i] ? acc_x_n[i] : OUT_W'($signed(joya[i*16+:8]));
        ay[i*OUT_W+:OUT_W] <= emu_n[i] ? acc_y_n[i] : OUT_W'($signed(joya[i*16+8+:8]));
      end
    end
  end
endmodule

// File: tb/tb_paddle_axis_emu.sv
// tb_paddle_axis_emu: directed and random packets checked against an arithmetic axis model.
module tb_paddle_axis_emu;
  localparam int N = 2, W = 8, SM = 10;
  localparam int HI = (1 << (W - 1)) - 1, LO = -(1 << (W - 1));
  logic clk_sys = 1'b0, reset = 1'b1;
  logic [25*N-1:0] ps2_mouse = '0;
  logic [16*N-1:0] joya = '0;
  logic [1:0] sens = 2'd0;
  logic invert_y = 1'b0, recenter = 1'b0;
  logic [W*N-1:0] ax, ay;
  logic [3*N-1:0] btn;
  logic [N-1:0] emu, upd, ovr;
  int n_chk = 0, n_fail = 0;
  int mx [N], my [N], mb [N];
  bit me [N];

  always #5 clk_sys = ~clk_sys;

  paddle_axis_emu #(.NUM_MICE(N), .OUT_W(W), .STEP_MAX(SM)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_mouse), .joya(joya), .sens(sens),
    .invert_y(invert_y), .recenter(recenter), .ax(ax), .ay(ay), .btn(btn), .emu(emu),
    .upd(upd), .ovr(ovr)
  );

  task automatic tick;
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // floor division by 2^s, i.e. what an arithmetic right shift means numerically
  function automatic int fdiv(input int v, input int s);
    int p;
    p = 1 << s;
    return v >= 0 ? v / p : -((-v + p - 1) / p);
  endfunction

  function automatic int mstep(input int acc, input int raw, input int s, input bit inv);
    int v;
    v = fdiv(raw, s);
    if (inv) v = -v;
    if (v > SM) v = SM;
    if (v < -SM) v = -SM;
    acc = acc + v;
    return acc > HI ? HI : acc < LO ? LO : acc;
  endfunction

  task automatic send(input int m, input int x, input int y, input int b);
    logic [24:0] p;
    p = ps2_mouse[m*25+:25];
    p[2:0] = b[2:0];
    p[4] = x < 0;
    p[5] = y < 0;
    p[15:8] = x[7:0];
    p[23:16] = y[7:0];
    p[24] = ~p[24];
    ps2_mouse[m*25+:25] = p;
  endtask

  task automatic apply(input int m, input int x, input int y, input int b);
    mx[m] = mstep(mx[m], x, int'(sens), 1'b0);
    my[m] = mstep(my[m], y, int'(sens), invert_y);
    me[m] = 1'b1;
    mb[m] = b;
  endtask

  task automatic check_ch(input int m, input string tag);
    chk($sformatf("%s ax%0d", tag, m), sx(ax[m*W+:W]), me[m] ? mx[m] : int'($signed(joya[m*16+:8])));
    chk($sformatf("%s ay%0d", tag, m), sx(ay[m*W+:W]), me[m] ? my[m] : int'($signed(joya[m*16+8+:8])));
    chk($sformatf("%s emu%0d", tag, m), int'(emu[m]), int'(me[m]));
    chk($sformatf("%s btn%0d", tag, m), int'(btn[m*3+:3]), mb[m]);
  endtask

  task automatic wait_upd(input int m, output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (upd[m]) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic pkt(input int m, input int x, input int y, input int b, input string tag);
    int lat;
    send(m, x, y, b);
    wait_upd(m, lat);
    chk({tag, " latency"}, lat, 4);
    apply(m, x, y, b);
    check_ch(m, tag);
  endtask

  initial begin
    int f0, f1, n, px, py, m, x, y, b;
    for (int i = 0; i < N; i++) begin
      mx[i] = 0; my[i] = 0; mb[i] = 0; me[i] = 1'b0;
    end
    ps2_mouse[24] = 1'b1;
    ps2_mouse[49] = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("reset upd", int'(upd), 0);
      chk("reset emu", int'(emu), 0);
      chk("reset ax", int'(ax), 0);
      chk("reset ay", int'(ay), 0);
    end
    pkt(0, 5, -3, 1, "basic");
    chk("basic ax const", sx(ax[W-1:0]), 5);
    chk("basic ay const", sx(ay[W-1:0]), -3);
    for (int i = 0; i < 20; i++) pkt(0, 100, 0, 2, "sat");
    chk("sat ax const", sx(ax[W-1:0]), 127);
    pkt(0, -200, 0, 2, "unsat");
    chk("unsat ax const", sx(ax[W-1:0]), 117);
    send(0, 7, 2, 3);
    send(1, -9, 6, 4);
    apply(0, 7, 2, 3);
    apply(1, -9, 6, 4);
    f0 = -1;
    f1 = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (upd[0] && f0 < 0) f0 = c;
      if (upd[1] && f1 < 0) f1 = c;
    end
    chk("dual lat0", f0, 4);
    chk("dual lat1", f1, 8);
    check_ch(0, "dual");
    check_ch(1, "dual");
    chk("dual ovr", int'(ovr), 0);
    send(0, 3, 3, 1);
    tick();
    send(0, -4, 8, 6);
    n = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      n += int'(upd[0]);
    end
    chk("overrun upd count", n, 1);
    apply(0, -4, 8, 6);
    check_ch(0, "overrun");
    chk("overrun ovr0", int'(ovr[0]), 1);
    sens = 2'd2;
    px = sx(ax[W-1:0]);
    pkt(0, -7, 0, 0, "sens2");
    chk("sens2 dx", sx(ax[W-1:0]) - px, -2);
    sens = 2'd0;
    invert_y = 1'b1;
    py = sx(ay[W-1:0]);
    pkt(0, 0, 4, 0, "invy");
    chk("invy dy", sx(ay[W-1:0]) - py, -4);
    for (int i = 0; i < 12; i++) begin
      m = int'($urandom_range(0, N - 1));
      x = int'($urandom_range(0, 511)) - 256;
      y = int'($urandom_range(0, 511)) - 256;
      b = int'($urandom_range(0, 7));
      sens = 2'($urandom_range(0, 3));
      invert_y = 1'($urandom_range(0, 1));
      pkt(m, x, y, b, $sformatf("rand%0d", i));
    end
    sens = 2'd0;
    invert_y = 1'b0;
    send(0, 5, 5, 7);
    tick();
    tick();
    tick();
    joya[15:0] = 16'h0040;
    tick();
    mx[0] = 0; my[0] = 0; mb[0] = 0; me[0] = 1'b0;
    check_ch(0, "override");
    chk("override ax const", sx(ax[W-1:0]), 64);
    chk("override upd", int'(upd[0]), 0);
    recenter = 1'b1;
    tick();
    recenter = 1'b0;
    for (int i = 0; i < N; i++) begin
      mx[i] = 0;
      my[i] = 0;
    end
    chk("recenter upd", int'(upd[0]), 0);
    chk("recenter ovr", int'(ovr), 0);
    check_ch(1, "recenter");
    joya = '0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n += int'(upd[0]);
    end
    chk("override no upd", n, 0);
    check_ch(0, "released");
    pkt(0, 3, -2, 5, "after");
    chk("after ax const", sx(ax[W-1:0]), 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
